// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded instruction fields into RV32I words and loads them into IMEM
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            op_class,
  input  logic [2:0]            funct3,
  input  logic                  alt,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  full;
  logic                  hs;
  logic                  illegal;
  logic                  fit12, fit13, fit21, shift;
  logic [31:0]           word, enc;

  assign hs = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = RUN;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs && in_last) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Range checks: all bits above the sign bit must replicate it.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);
  assign shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (op_class)
      3'd0: begin
        word    = {(alt ? 7'b0100000 : 7'b0), rs2, rs1, funct3, rd, 7'b0110011};
        illegal = alt && !((funct3 == 3'b000) || (funct3 == 3'b101));
      end
      3'd1: begin
        if (shift) begin
          word    = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011};
          illegal = alt && (funct3 != 3'b101);
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, 7'b0010011};
          illegal = alt || !fit12;
        end
      end
      3'd2: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b0000011};
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) || !fit12;
      end
      3'd3: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
        illegal = (funct3 > 3'b010) || !fit12;
      end
      3'd4: word = {imm[31:12], rd, 7'b0110111};
      3'd5: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011) || !fit13 || imm[0];
      end
      3'd6: begin
        word    = {imm[11:0], rs1, funct3, rd, 7'b1100111};
        illegal = (funct3 != 3'b000) || !fit12;
      end
      default: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        illegal = !fit21 || imm[0];
      end
    endcase
    enc = illegal ? NOP : word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      full       <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= (state == FINISH);
      if (state == IDLE && start) begin
        addr  <= BASE;
        full  <= 1'b0;
        count <= '0;
        error <= 1'b0;
      end
      if (hs) begin
        // Once the top word is written, further bundles are consumed but dropped.
        if (full) begin
          error <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= addr;
          imem_wdata <= enc;
          count      <= count + (ADDR_WIDTH+1)'(1);
          if (illegal) error <= 1'b1;
          if (addr == '1) full <= 1'b1;
          else            addr <= addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed bench for instr_encoder_loader (default and ADDR_WIDTH=2 instances)
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  op_class = '0;
  logic [2:0]  funct3 = '0;
  logic        alt = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        a_ready, a_we, a_busy, a_done, a_error;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_count;

  logic        b_ready, b_we, b_busy, b_done, b_error;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_last(in_last), .op_class(op_class), .funct3(funct3), .alt(alt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .error(a_error), .count(a_count)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_last(in_last), .op_class(op_class), .funct3(funct3), .alt(alt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .error(b_error), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] f3, input logic a,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im, input logic last);
    in_valid = 1'b1;
    op_class = c;
    funct3   = f3;
    alt      = a;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    imm      = im;
    in_last  = last;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_chk(input string tag, input logic [31:0] ad, input logic [31:0] wd);
    chk({tag, "_we"}, a_we, 1'b1);
    chk({tag, "_addr"}, a_addr, ad);
    chk({tag, "_wdata"}, a_wdata, wd);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_we", a_we, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_count", a_count, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", a_ready, 1'b0);

    // single ADDI
    go();
    chk("run_ready", a_ready, 1'b1);
    chk("run_busy", a_busy, 1'b1);
    drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    write_chk("addi", 0, 32'h0050_0093);
    chk("fin_busy", a_busy, 1'b1);
    chk("fin_done", a_done, 1'b0);
    tick();
    chk("t1_done", a_done, 1'b1);
    chk("t1_we_off", a_we, 1'b0);
    chk("t1_count", a_count, 1);
    chk("t1_error", a_error, 1'b0);
    chk("t1_busy", a_busy, 1'b0);
    tick();
    chk("t1_done_pulse", a_done, 1'b0);

    // back-to-back SUB / SW / BNE
    go();
    drive(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    tick();
    write_chk("sub", 0, 32'h4020_81B3);
    drive(3'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    tick();
    write_chk("sw", 1, 32'h0020_A423);
    drive(3'd5, 3'b001, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1);
    tick();
    in_valid = 1'b0;
    write_chk("bne", 2, 32'hFE20_9EE3);
    tick();
    chk("t2_done", a_done, 1'b1);
    chk("t2_count", a_count, 3);

    // JAL / LUI / illegal LOAD
    go();
    drive(3'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    tick();
    write_chk("jal", 0, 32'h0080_00EF);
    drive(3'd4, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    tick();
    write_chk("lui", 1, 32'h1234_52B7);
    chk("lui_error", a_error, 1'b0);
    drive(3'd2, 3'b011, 1'b0, 5'd4, 5'd1, 5'd0, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    write_chk("ld_bad", 2, 32'h0000_0013);
    chk("ld_bad_error", a_error, 1'b1);
    tick();
    chk("t3_done", a_done, 1'b1);
    chk("t3_count", a_count, 3);
    tick();
    chk("t3_error_sticky", a_error, 1'b1);
    go();
    chk("t3_error_clear", a_error, 1'b0);

    // SRAI with ignored imm[11:5], JALR negative, out-of-range ADDI
    drive(3'd1, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'h0000_0FE3, 1'b0);
    tick();
    write_chk("srai", 0, 32'h4030_D093);
    chk("srai_error", a_error, 1'b0);
    drive(3'd6, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    write_chk("jalr", 1, 32'hFFF1_00E7);
    chk("jalr_error", a_error, 1'b0);
    drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    tick();
    write_chk("addi_big", 2, 32'h0000_0013);
    chk("addi_big_error", a_error, 1'b1);
    drive(3'd5, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    write_chk("beq_odd", 3, 32'h0000_0013);
    tick();
    chk("t4_done", a_done, 1'b1);

    // overflow on the ADDR_WIDTH=2 instance
    go();
    for (int i = 0; i < 5; i++) begin
      drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, i == 4);
      tick();
      if (i < 4) begin
        chk("ovf_we", b_we, 1'b1);
        chk("ovf_addr", b_addr, i);
        chk("ovf_error_lo", b_error, 1'b0);
      end else begin
        chk("ovf_we_supp", b_we, 1'b0);
        chk("ovf_error", b_error, 1'b1);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("ovf_done", b_done, 1'b1);
    chk("ovf_count", b_count, 4);
    chk("ovf_a_count", a_count, 5);

    // reset mid-session with a handshake pending
    go();
    drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
    tick();
    chk("pre_rst_we", a_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_we", a_we, 1'b0);
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_count", a_count, 0);
    chk("arst_wdata", a_wdata, 0);
    tick();
    chk("rst_hold_we", a_we, 1'b0);
    chk("rst_hold_ready", a_ready, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    go();
    drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    write_chk("post_rst", 0, 32'h0050_0093);
    tick();
    chk("post_rst_count", a_count, 1);

    // start during RUN is ignored
    go();
    drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    tick();
    write_chk("s0", 0, 32'h0050_0093);
    start = 1'b1;
    tick();
    start = 1'b0;
    write_chk("s1", 1, 32'h0050_0093);
    drive(3'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    write_chk("s2", 2, 32'h0050_0093);
    tick();
    chk("s_done", a_done, 1'b1);
    chk("s_count", a_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Instruction encoder and program loader. It is the inverse of the core's control decoder.
- Accepts decoded instruction fields (class, funct3, alt bit, register indices, immediate) over a valid/ready stream and packs them into RV32I machine words.
- Writes each word sequentially into instruction memory through a registered write port.
- Used by boot and self-test logic to build programs in IMEM without an external assembler.

Parameters:
- ADDR_WIDTH, 10, IMEM word-address width.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a load session (honoured only in IDLE)
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_last  in  1  bundle is the final instruction of the session
- op_class  in  3  0=OP, 1=OP_IMM, 2=LOAD, 3=STORE, 4=LUI, 5=BRANCH, 6=JALR, 7=JAL
- funct3  in  3  instr[14:12]
- alt  in  1  funct7[5] select (SUB/SRA/SRAI)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  immediate as a signed byte offset or value; for LUI, imm[31:12] is used
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_WIDTH  IMEM word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active
- done  out  1  one-cycle pulse when the session completes
- error  out  1  sticky; an illegal bundle or address overflow has occurred
- count  out  ADDR_WIDTH+1  words written this session

Behaviour:
- Reset (async, immediate) drives all outputs to 0 and the state to IDLE. Reset mid-session abandons the session; no partial write is issued after reset asserts.
- States: IDLE, RUN, FINISH.
  - IDLE: in_ready=0. start -> RUN; the address register loads BASE_ADDR, and count and error clear.
  - RUN: in_ready=1 every cycle.
  - A handshake (in_valid & in_ready) at cycle N produces imem_we=1, imem_addr=current address and imem_wdata=encoded word at cycle N+1 (registered, latency 1). The address and count increment after the write.
  - A handshake with in_last=1 -> FINISH.
  - FINISH: the final write is presented. done=1 for exactly one cycle in the cycle after that write, then IDLE. busy=1 in RUN and FINISH.
- start while busy is ignored.
- Back-to-back handshakes produce one write per cycle with no bubbles.
- Encoding:
  - Opcodes are 0110011, 0010011, 0000011, 0100011, 0110111, 1100011, 1100111, 1101111.
  - I-type: imm[11:0] goes to [31:20]. For OP_IMM funct3 001/101, [24:20]=imm[4:0] and [31:25]=alt?0100000:0000000.
  - S-type: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B-type: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U-type: [31:12]=imm[31:12].
  - J-type: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - OP: [31:25]=alt?0100000:0000000.
  - Fields not used by a class are zero.
- Illegal bundles encode as NOP 0x00000013 and set error; the write still occurs and the address still advances. A bundle is illegal if any of the following holds:
  - LOAD funct3 is not in {000,001,010,100,101}.
  - STORE funct3 is greater than 010.
  - BRANCH funct3 is 010 or 011.
  - JALR funct3 is not 000.
  - OP has alt=1 with funct3 not in {000,101}.
  - OP_IMM has alt=1 with funct3 not 101.
  - An I-type or S-type imm does not fit in signed 12 bits.
  - A B-type imm does not fit in signed 13 bits, or imm[0]=1.
  - A J-type imm does not fit in signed 21 bits, or imm[0]=1.
  - For shift immediates, imm[11:5] is ignored and alt is used instead.
- Overflow:
  - A write at the maximum address (2^ADDR_WIDTH-1) is legal.
  - Any further handshake sets error and suppresses imem_we. The address does not wrap. The bundle is still consumed and in_last is still honoured.
- error persists until the next accepted start or reset.

Test Plan:
- start; OP_IMM f3=000 rd=1 rs1=0 imm=5, in_last=1 -> one cycle later imem_we=1, addr=0, wdata=0x00500093; done pulses the next cycle; count=1; error=0.
- Three back-to-back bundles: OP f3=000 alt=1 rd=3 rs1=1 rs2=2; STORE f3=010 rs1=1 rs2=2 imm=8; BRANCH f3=001 rs1=1 rs2=2 imm=-4 (last) -> consecutive writes 0x402081B3 @0, 0x0020A423 @1, 0xFE209EE3 @2, with no gaps.
- Three bundles: JAL rd=1 imm=8 -> 0x008000EF; LUI rd=5 imm=0x12345000 -> 0x123452B7; LOAD f3=011 -> 0x00000013 with error=1 sticky; the address still advances to 3.
- ADDR_WIDTH=2: five bundles -> writes at addresses 0..3, fifth write suppressed, error=1, done still pulses, count=4.
- Reset asserted one cycle after a handshake -> no imem_we in the following cycle; all outputs 0; IDLE; a new start then writes at BASE_ADDR.
- start pulsed during RUN -> ignored; address sequence and count continue unaffected.
